// File: rtl/bcd_pkg.sv
// ---------------------------------------------------------------------------
// bcd_pkg
// Shared types and constants for the BCD-to-binary converter:
//   N_DIG_DEF / BIN_W_DEF : default digit count and binary output width
//   bcd_digit_t           : one packed BCD digit
//   state_t               : converter FSM states (IDLE, CONV)
//   BCD_DIG_MAX           : largest legal BCD digit value
//   digito_invalido()     : true when a nibble is not a legal BCD digit
// ---------------------------------------------------------------------------
package bcd_pkg;

   localparam int N_DIG_DEF = 3;
   localparam int BIN_W_DEF = 10;

   typedef logic [3:0] bcd_digit_t;

   typedef enum logic {
      IDLE = 1'b0,
      CONV = 1'b1
   } state_t;

   localparam bcd_digit_t BCD_DIG_MAX = 4'd9;

   function automatic logic digito_invalido(input bcd_digit_t dig);
      return (dig > BCD_DIG_MAX);
   endfunction

endpackage

// File: rtl/bcd_a_binario_if.sv
// ---------------------------------------------------------------------------
// bcd_a_binario_if
// Request/result bundle of the BCD-to-binary converter.
//   start   : conversion request (master -> slave)
//   bcd_in  : packed BCD word, digit 0 in bits [3:0] (master -> slave)
//   ready   : converter idle, start can be accepted (slave -> master)
//   done    : one enabled-cycle pulse, bin_out/err valid (slave -> master)
//   bin_out : binary result, held until the next done (slave -> master)
//   err     : invalid-digit flag, valid with done (slave -> master)
// ---------------------------------------------------------------------------
interface bcd_a_binario_if #(
   parameter int N_DIG = 3,
   parameter int BIN_W = 10
);
   logic                 start;
   logic [4*N_DIG-1:0]   bcd_in;
   logic                 ready;
   logic                 done;
   logic [BIN_W-1:0]     bin_out;
   logic                 err;

   modport master (
      output start, bcd_in,
      input  ready, done, bin_out, err
   );

   modport slave (
      input  start, bcd_in,
      output ready, done, bin_out, err
   );
endinterface

// File: rtl/bcd_ajuste_digito.sv
// ---------------------------------------------------------------------------
// bcd_ajuste_digito
// Per-digit correction of the reverse double-dabble step: after the right
// shift a digit that reads 8 or more carried a "ten" into the bit below it,
// which is worth 5 there instead of 8, so 3 is subtracted.
//   dig_i : digit after the shift
//   dig_o : corrected digit
// ---------------------------------------------------------------------------
module bcd_ajuste_digito
   import bcd_pkg::*;
(
   input  bcd_digit_t dig_i,
   output bcd_digit_t dig_o
);

   assign dig_o = (dig_i >= 4'd8) ? (dig_i - 4'd3) : dig_i;

endmodule

// File: rtl/bcd_a_binario.sv
// ---------------------------------------------------------------------------
// bcd_a_binario
// Sequential BCD-to-binary converter (reverse double-dabble), one bit per
// enabled clock, start/ready/done handshake.
//   clk    : clock, rising edge
//   rst    : synchronous active-high reset
//   clk_en : advances the block when 1, freezes all state when 0
//   bus    : bcd_a_binario_if.slave (start, bcd_in, ready, done, bin_out, err)
// Optional feature macro: BCD_A_BIN_CHECK_EN
//   defined   : illegal digits are rejected on the accepting edge and reported
//               one enabled edge later with done=1, err=1, bin_out=0
//   undefined : err is tied to 0 and digits are not checked
// ---------------------------------------------------------------------------
module bcd_a_binario
   import bcd_pkg::*;
#(
   parameter int N_DIG = N_DIG_DEF,
   parameter int BIN_W = BIN_W_DEF
)(
   input  logic              clk,
   input  logic              rst,
   input  logic              clk_en,
   bcd_a_binario_if.slave    bus
);

   localparam int D_W  = 4 * N_DIG;
   localparam int SR_W = 2 * D_W;
   localparam int IT_W = $clog2(D_W);
   localparam logic [IT_W-1:0] IT_LAST = IT_W'(D_W - 1);

   state_t              state_q, state_d;
   logic [SR_W-1:0]     sr_q, sr_d;
   logic [IT_W-1:0]     it_q, it_d;
   logic                done_q, done_d;
   logic [BIN_W-1:0]    bin_q, bin_d;
   logic [SR_W-1:0]     sr_shift_s;
   logic [SR_W-1:0]     sr_adj_s;

`ifdef BCD_A_BIN_CHECK_EN
   logic                err_q, err_d;
   logic                pend_q, pend_d;
   logic                bcd_invalido_s;
`endif

   // Right shift: BCD LSB falls into the binary MSB.
   assign sr_shift_s = {1'b0, sr_q[SR_W-1:1]};
   // Binary field passes through untouched; only BCD digits get corrected.
   assign sr_adj_s[D_W-1:0] = sr_shift_s[D_W-1:0];

   for (genvar g = 0; g < N_DIG; g++) begin : g_ajuste
      bcd_ajuste_digito u_ajuste (
         .dig_i (sr_shift_s[D_W + 4*g +: 4]),
         .dig_o (sr_adj_s  [D_W + 4*g +: 4])
      );
   end

`ifdef BCD_A_BIN_CHECK_EN
   // Flags any nibble of the incoming word above 9.
   always_comb begin
      bcd_invalido_s = 1'b0;
      for (int i = 0; i < N_DIG; i++) begin
         if (digito_invalido(bus.bcd_in[4*i +: 4])) begin
            bcd_invalido_s = 1'b1;
         end else begin
            bcd_invalido_s = bcd_invalido_s;
         end
      end
   end
`endif

   // Next-state and datapath decode; everything holds unless clk_en is high.
   always_comb begin
      state_d = state_q;
      sr_d    = sr_q;
      it_d    = it_q;
      done_d  = done_q;
      bin_d   = bin_q;
`ifdef BCD_A_BIN_CHECK_EN
      err_d   = err_q;
      pend_d  = pend_q;
`endif
      if (clk_en) begin
         done_d = 1'b0;
`ifdef BCD_A_BIN_CHECK_EN
         // A word rejected on the previous enabled edge is reported now.
         if (pend_q) begin
            done_d = 1'b1;
            err_d  = 1'b1;
            bin_d  = '0;
            pend_d = 1'b0;
         end else begin
            pend_d = 1'b0;
         end
`endif
         case (state_q)
            IDLE: begin
               if (bus.start) begin
`ifdef BCD_A_BIN_CHECK_EN
                  if (bcd_invalido_s) begin
                     pend_d = 1'b1;
                  end else begin
                     state_d = CONV;
                     sr_d    = {bus.bcd_in, {D_W{1'b0}}};
                     it_d    = '0;
                  end
`else
                  state_d = CONV;
                  sr_d    = {bus.bcd_in, {D_W{1'b0}}};
                  it_d    = '0;
`endif
               end else begin
                  state_d = IDLE;
               end
            end
            CONV: begin
               sr_d = sr_adj_s;
               if (it_q == IT_LAST) begin
                  state_d = IDLE;
                  it_d    = '0;
                  done_d  = 1'b1;
                  bin_d   = sr_adj_s[BIN_W-1:0];
`ifdef BCD_A_BIN_CHECK_EN
                  err_d   = 1'b0;
`endif
               end else begin
                  it_d = it_q + IT_W'(1);
               end
            end
            default: begin
               state_d = IDLE;
            end
         endcase
      end else begin
         done_d = done_q;
      end
   end

   // State and output registers with synchronous reset.
   always_ff @(posedge clk) begin
      if (rst) begin
         state_q <= IDLE;
         sr_q    <= '0;
         it_q    <= '0;
         done_q  <= 1'b0;
         bin_q   <= '0;
`ifdef BCD_A_BIN_CHECK_EN
         err_q   <= 1'b0;
         pend_q  <= 1'b0;
`endif
      end else begin
         state_q <= state_d;
         sr_q    <= sr_d;
         it_q    <= it_d;
         done_q  <= done_d;
         bin_q   <= bin_d;
`ifdef BCD_A_BIN_CHECK_EN
         err_q   <= err_d;
         pend_q  <= pend_d;
`endif
      end
   end

   assign bus.ready   = (state_q == IDLE);
   assign bus.done    = done_q;
   assign bus.bin_out = bin_q;
`ifdef BCD_A_BIN_CHECK_EN
   assign bus.err     = err_q;
`else
   assign bus.err     = 1'b0;
`endif

endmodule

// File: tb/tb_bcd_a_binario.sv
module tb_bcd_a_binario;

   logic clk;
   logic rst;
   logic clk_en;

   int checks;
   int failures;

   bcd_a_binario_if #(.N_DIG(3), .BIN_W(10)) bus ();

   bcd_a_binario #(.N_DIG(3), .BIN_W(10)) dut (
      .clk    (clk),
      .rst    (rst),
      .clk_en (clk_en),
      .bus    (bus)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   typedef struct {
      logic [11:0] bcd;
      int          exp;
   } vec_t;

   vec_t vecs[8];

   task automatic check(input string name, input int act, input int exp);
      checks++;
      if (act != exp) begin
         failures++;
         $display("FAIL %s: got %0d expected %0d", name, act, exp);
      end
   endtask

   // Advance one rising edge and settle just after it.
   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   // Issue a start, then count edges until done (bounded).
   task automatic run_conv(input logic [11:0] bcd, input string name,
                           output int bin, output int lat);
      bus.start  = 1'b1;
      bus.bcd_in = bcd;
      tick();
      bus.start  = 1'b0;
      check({name, "_ready_low"}, int'(bus.ready), 0);
      check({name, "_done_cleared"}, int'(bus.done), 0);
      lat = 0;
      while (bus.done !== 1'b1 && lat < 40) begin
         tick();
         lat++;
      end
      if (bus.done !== 1'b1) begin
         failures++;
         checks++;
         $display("FAIL %s_timeout: got no done after %0d edges, expected done", name, lat);
      end
      bin = int'(bus.bin_out);
   endtask

   initial begin
      int bin;
      int lat;
      checks   = 0;
      failures = 0;

      vecs[0] = '{12'h123, 123};
      vecs[1] = '{12'h000, 0};
      vecs[2] = '{12'h999, 999};
      vecs[3] = '{12'h001, 1};
      vecs[4] = '{12'h090, 90};
      vecs[5] = '{12'h500, 500};
      vecs[6] = '{12'h987, 987};
      vecs[7] = '{12'h042, 42};

      rst        = 1'b1;
      clk_en     = 1'b1;
      bus.start  = 1'b0;
      bus.bcd_in = 12'h000;
      tick();
      tick();
      rst = 1'b0;
      check("rst_ready", int'(bus.ready), 1);
      check("rst_done", int'(bus.done), 0);
      check("rst_bin", int'(bus.bin_out), 0);
      check("rst_err", int'(bus.err), 0);

      // Table: each start issued in the done cycle of the previous one.
      for (int i = 0; i < 8; i++) begin
         run_conv(vecs[i].bcd, $sformatf("vec%0d", i), bin, lat);
         check($sformatf("vec%0d_lat", i), lat, 12);
         check($sformatf("vec%0d_bin", i), bin, vecs[i].exp);
         check($sformatf("vec%0d_err", i), int'(bus.err), 0);
         check($sformatf("vec%0d_ready_at_done", i), int'(bus.ready), 1);
      end
      tick();
      check("done_pulse_one_cycle", int'(bus.done), 0);
      check("bin_holds", int'(bus.bin_out), 42);

      // Start while busy is ignored.
      bus.start  = 1'b1;
      bus.bcd_in = 12'h456;
      tick();
      bus.start = 1'b0;
      lat = 0;
      for (int c = 1; c <= 4; c++) begin
         tick();
         lat++;
      end
      bus.start  = 1'b1;
      bus.bcd_in = 12'h111;
      tick();
      lat++;
      bus.start  = 1'b0;
      while (bus.done !== 1'b1 && lat < 40) begin
         tick();
         lat++;
      end
      check("ign_lat", lat, 12);
      check("ign_bin", int'(bus.bin_out), 456);
      tick();
      check("ign_no_second", int'(bus.ready), 1);

      // clk_en gap of 3 cycles mid-conversion.
      bus.start  = 1'b1;
      bus.bcd_in = 12'h050;
      tick();
      bus.start = 1'b0;
      lat = 0;
      for (int c = 0; c < 4; c++) begin
         tick();
         lat++;
      end
      clk_en = 1'b0;
      for (int c = 0; c < 3; c++) begin
         tick();
         lat++;
      end
      check("en_frozen_ready", int'(bus.ready), 0);
      clk_en = 1'b1;
      while (bus.done !== 1'b1 && lat < 40) begin
         tick();
         lat++;
      end
      check("en_lat", lat, 15);
      check("en_bin", int'(bus.bin_out), 50);
      clk_en = 1'b0;
      tick();
      tick();
      check("en_done_holds", int'(bus.done), 1);
      check("en_bin_holds", int'(bus.bin_out), 50);
      clk_en = 1'b1;
      tick();
      check("en_done_clears", int'(bus.done), 0);

      // Reset in the middle of a conversion.
      bus.start  = 1'b1;
      bus.bcd_in = 12'h777;
      tick();
      bus.start = 1'b0;
      for (int c = 0; c < 5; c++) tick();
      rst = 1'b1;
      tick();
      rst = 1'b0;
      check("mid_rst_ready", int'(bus.ready), 1);
      check("mid_rst_done", int'(bus.done), 0);
      check("mid_rst_bin", int'(bus.bin_out), 0);
      run_conv(12'h042, "after_rst", bin, lat);
      check("after_rst_lat", lat, 12);
      check("after_rst_bin", bin, 42);
      tick();

      // Invalid digit.
`ifdef BCD_A_BIN_CHECK_EN
      bus.start  = 1'b1;
      bus.bcd_in = 12'h1A5;
      tick();
      bus.start = 1'b0;
      check("inv_ready", int'(bus.ready), 1);
      check("inv_done_early", int'(bus.done), 0);
      tick();
      check("inv_done", int'(bus.done), 1);
      check("inv_err", int'(bus.err), 1);
      check("inv_bin", int'(bus.bin_out), 0);
      run_conv(12'h123, "after_inv", bin, lat);
      check("after_inv_bin", bin, 123);
      check("after_inv_err", int'(bus.err), 0);
`else
      run_conv(12'h1A5, "inv", bin, lat);
      check("inv_lat", lat, 12);
      check("inv_err", int'(bus.err), 0);
`endif

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
